mem_port_arbiter: RTL

Single-cycle-decision arbiter that shares the one unified instruction/data memory between the fetch stage (instruction port) and the memory/write-back stage (data port). Per cycle it grants at most one requester and drives the single-port synchronous memory. It steers read data back to the owner one cycle later and bounds-checks addresses. Data accesses have priority; a starvation counter guarantees fetch forward progress.

---
 rtl/mem_port_arbiter.sv | 74 +++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between the fetch and data ports.
// Data has priority unless fetch has been starved; read data is steered back a cycle later.
module mem_port_arbiter #(
  parameter int unsigned MEM_DEPTH   = 1024,
  parameter int unsigned IF_MAX_WAIT = 3
) (
  input  logic        clk1,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {IDLE, RD_IF, RD_D, WR_D, ERR_IF, ERR_D} owner_e;

  owner_e     state;
  logic       err_ld;
  logic [3:0] starve_cnt;
  logic       if_ok, d_ok, if_win;

  assign if_ok  = if_addr < 32'(MEM_DEPTH);
  assign d_ok   = d_addr < 32'(MEM_DEPTH);
  assign if_win = if_req && (!d_req || starve_cnt >= 4'(IF_MAX_WAIT));

  assign if_gnt    = rst_n && if_win;
  assign d_gnt     = rst_n && d_req && !if_win;
  // Out-of-range winners still get their grant but never reach the memory.
  assign mem_en    = (if_gnt && if_ok) || (d_gnt && d_ok);
  assign mem_we    = d_gnt && d_ok && d_we;
  assign mem_addr  = if_gnt ? if_addr : (d_gnt ? d_addr : '0);
  assign mem_wdata = mem_we ? d_wdata : '0;

  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      state      <= IDLE;
      err_ld     <= 1'b0;
      starve_cnt <= '0;
    end else begin
      err_ld <= !d_we;
      if (if_gnt)     state <= if_ok ? RD_IF : ERR_IF;
      else if (d_gnt) state <= !d_ok ? ERR_D : (d_we ? WR_D : RD_D);
      else            state <= IDLE;
      if (if_req && !if_gnt)
        starve_cnt <= (starve_cnt == 4'hf) ? starve_cnt : starve_cnt + 4'd1;
      else
        starve_cnt <= '0;
    end
  end

  // Responses are masked while reset is asserted so an in-flight read is dropped.
  assign if_rvalid = rst_n && (state == RD_IF || state == ERR_IF);
  assign if_err    = rst_n && (state == ERR_IF);
  assign if_rdata  = (rst_n && state == RD_IF) ? mem_rdata : '0;
  assign d_rvalid  = rst_n && (state == RD_D || (state == ERR_D && err_ld));
  assign d_err     = rst_n && (state == ERR_D);
  assign d_rdata   = (rst_n && state == RD_D) ? mem_rdata : '0;

endmodule
